// File: rtl/uart_tx_arbiter_if.sv
// Producer handshakes and transmitter-side signals of uart_tx_arbiter.
// The slave view belongs to the arbiter. The master view belongs to the producers and the transmitter.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              tx_busy_i;
  logic              tx_send_o;
  logic [DATA_W-1:0] tx_data_o;
  logic [1:0]        grant_o;
  logic              ack_err_o;
  logic              ack_err_clr_i;
  logic [2:0]        ctrl_state_o;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy_i, ack_err_clr_i,
    output req0_ready, req1_ready, tx_send_o, tx_data_o, grant_o, ack_err_o, ctrl_state_o
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy_i, ack_err_clr_i,
    input  req0_ready, req1_ready, tx_send_o, tx_data_o, grant_o, ack_err_o, ctrl_state_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between two byte producers.
// It tracks the transmitter's busy flag through each frame and inserts a programmable inter-frame gap.
module uart_tx_arbiter #(
  parameter int DATA_W      = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t            r_state, w_stateNxt;
  logic [DATA_W-1:0] r_data, w_dataNxt;
  logic [1:0]        r_grant, w_grantNxt;
  logic              r_last, w_lastNxt;
  logic [ACK_W-1:0]  r_ackCnt, w_ackCntNxt;
  logic [GAP_W-1:0]  r_gapCnt, w_gapCntNxt;
  logic              r_ackErr;
  logic              w_ackErrSet;
  logic              w_arbOpen;
  logic              w_winner;
  logic              w_take0;
  logic              w_take1;

  // A tie goes to the requester that was not granted last; r_last=1 means req1.
  assign w_arbOpen = (r_state == IDLE) && !bus.tx_busy_i && !rst;
  assign w_winner  = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
  assign w_take0   = w_arbOpen && bus.req0_valid && !w_winner;
  assign w_take1   = w_arbOpen && bus.req1_valid && w_winner;

  assign bus.req0_ready   = w_take0;
  assign bus.req1_ready   = w_take1;
  assign bus.tx_send_o    = (r_state == SEND);
  assign bus.tx_data_o    = r_data;
  assign bus.grant_o      = r_grant;
  assign bus.ack_err_o    = r_ackErr;
  assign bus.ctrl_state_o = r_state;

  always_comb begin
    w_stateNxt  = r_state;
    w_dataNxt   = r_data;
    w_grantNxt  = r_grant;
    w_lastNxt   = r_last;
    w_ackCntNxt = r_ackCnt;
    w_gapCntNxt = '0;
    w_ackErrSet = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_take0 || w_take1) begin
          w_dataNxt  = w_take1 ? bus.req1_data : bus.req0_data;
          w_grantNxt = w_take1 ? 2'b10 : 2'b01;
          w_lastNxt  = w_take1;
          w_stateNxt = SEND;
        end
      end
      SEND: begin
        w_ackCntNxt = '0;
        w_stateNxt  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy_i) begin
          w_stateNxt = WAIT_DONE;
        end else if (r_ackCnt == ACK_LAST) begin
          // The transmitter never acknowledged the strobe, so the byte is dropped and no gap follows.
          w_ackErrSet = 1'b1;
          w_grantNxt  = 2'b00;
          w_stateNxt  = IDLE;
        end else begin
          w_ackCntNxt = r_ackCnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy_i) begin
          w_grantNxt = 2'b00;
          w_stateNxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (r_gapCnt == GAP_LAST) begin
          w_stateNxt = IDLE;
        end else begin
          w_gapCntNxt = r_gapCnt + 1'b1;
        end
      end
      default: begin
        w_grantNxt = 2'b00;
        w_stateNxt = IDLE;
      end
    endcase
  end

  // A set that coincides with a clear wins, so an error in the clear cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_ackCnt <= '0;
      r_gapCnt <= '0;
      r_ackErr <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_data   <= w_dataNxt;
      r_grant  <= w_grantNxt;
      r_last   <= w_lastNxt;
      r_ackCnt <= w_ackCntNxt;
      r_gapCnt <= w_gapCntNxt;
      r_ackErr <= w_ackErrSet | (r_ackErr & ~bus.ack_err_clr_i);
    end
  end

endmodule
